// File: rtl/fifo_rd_sched_if.sv
// Consumer and FIFO read-port bundle for fifo_rd_sched.
// Ports: req/req_len/rempty/rdata toward the scheduler; rinc/gnt/done/out_* from it.
interface fifo_rd_sched_if #(
    parameter int NREQ  = 4,
    parameter int IDW   = 2,
    parameter int LENW  = 4,
    parameter int DSIZE = 8
);
    logic [NREQ-1:0]      req;
    logic [NREQ*LENW-1:0] req_len;
    logic                 rempty;
    logic [DSIZE-1:0]     rdata;
    logic                 rinc;
    logic [NREQ-1:0]      gnt;
    logic                 done;
    logic                 out_valid;
    logic [DSIZE-1:0]     out_data;
    logic [IDW-1:0]       out_id;

    modport master (
        input  req, req_len, rempty, rdata,
        output rinc, gnt, done, out_valid, out_data, out_id
    );

    modport slave (
        output req, req_len, rempty, rdata,
        input  rinc, gnt, done, out_valid, out_data, out_id
    );
endinterface

// File: rtl/fifo_rd_sched.sv
// Round-robin, burst-granular read scheduler for the async FIFO (rclk domain).
// Ports: rclk, rrst_n (async active-low), bus (master: req/len in, rinc/gnt/out_* out).
module fifo_rd_sched #(
    parameter int NREQ  = 4,
    parameter int IDW   = 2,
    parameter int LENW  = 4,
    parameter int DSIZE = 8
) (
    input  logic            rclk,
    input  logic            rrst_n,
    fifo_rd_sched_if.master bus
);
    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] BURST = 1'b1;

    logic [0:0]       state;
    logic [LENW-1:0]  beats;
    logic [IDW-1:0]   rr_ptr;
    logic [IDW-1:0]   owner;
    logic [NREQ-1:0]  gnt_q;
    logic             done_q;
    logic             ov_q;
    logic [DSIZE-1:0] od_q;
    logic [IDW-1:0]   oid_q;

    logic             found;
    logic [IDW-1:0]   win;
    logic [IDW-1:0]   nxt_ptr;
    logic [LENW-1:0]  win_len;
    logic             rinc;
    int               idx;

    // First requester at or above rr_ptr, wrapping modulo NREQ.
    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = 0;
        for (int i = 0; i < NREQ; i++) begin
            idx = int'(rr_ptr) + i;
            if (idx >= NREQ) idx = idx - NREQ;
            if (!found && bus.req[idx]) begin
                found = 1'b1;
                win   = IDW'(idx);
            end
        end
    end

    always_comb begin
        win_len = bus.req_len[int'(win)*LENW +: LENW];
        nxt_ptr = (win == IDW'(NREQ - 1)) ? '0 : win + IDW'(1);
    end

    // Pop only while beats remain and data is present.
    assign rinc = (state == BURST) && (beats != '0) && !bus.rempty;

    assign bus.rinc      = rinc;
    assign bus.gnt       = gnt_q;
    assign bus.done      = done_q;
    assign bus.out_valid = ov_q;
    assign bus.out_data  = od_q;
    assign bus.out_id    = oid_q;

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            state  <= IDLE;
            beats  <= '0;
            rr_ptr <= '0;
            owner  <= '0;
            gnt_q  <= '0;
            done_q <= 1'b0;
            ov_q   <= 1'b0;
            od_q   <= '0;
            oid_q  <= '0;
        end else begin
            done_q <= 1'b0;
            ov_q   <= 1'b0;
            unique case (1'b1)
                (state == IDLE): begin
                    if (found) begin
                        gnt_q  <= NREQ'(1) << win;
                        beats  <= (win_len == '0) ? LENW'(1) : win_len;
                        rr_ptr <= nxt_ptr;
                        owner  <= win;
                        state  <= BURST;
                    end
                end
                (state == BURST): begin
                    if (rinc) begin
                        beats <= beats - LENW'(1);
                        ov_q  <= 1'b1;
                        od_q  <= bus.rdata;
                        oid_q <= owner;
                        // Last beat: grant drops with the done pulse.
                        if (beats == LENW'(1)) begin
                            done_q <= 1'b1;
                            gnt_q  <= '0;
                            state  <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
